// File: rtl/io_port_pkg.sv
// rtl/io_port_pkg.sv - shared types, window constants and decode helper for the I/O port responder
package io_port_pkg;

  localparam int NUM_PORTS = 16;

  typedef logic [3:0] port_idx_t;
  typedef logic [7:0] port_byte_t;

  localparam port_byte_t DEF_OUT_BASE = 8'hE0;
  localparam port_byte_t DEF_IN_BASE  = 8'hF0;

  // Windows are 16-aligned, so a hit is a match on the upper nibble.
  function automatic logic win_hit(input port_byte_t addr, input port_byte_t base);
    return addr[7:4] == base[7:4];
  endfunction

endpackage

// File: rtl/io_sync.sv
// rtl/io_sync.sv - single-bit multi-flop synchronizer with async active-low reset
module io_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/io_port_responder.sv
// rtl/io_port_responder.sv - CPU-facing I/O port window responder; optional IO_CHANGE_IRQ_EN input-change interrupt
module io_port_responder
  import io_port_pkg::*;
#(
  parameter port_byte_t OUT_BASE    = DEF_OUT_BASE,
  parameter port_byte_t IN_BASE     = DEF_IN_BASE,
  parameter int         SYNC_STAGES = 2,
  parameter port_byte_t OUT_RST_VAL = 8'h00
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   cpu_addr,
  input  logic [7:0]                   cpu_wdata,
  input  logic                         cpu_we,
  input  logic                         cpu_re,
  output logic [7:0]                   cpu_rdata,
  output logic                         cpu_rvalid,
  input  logic [NUM_PORTS-1:0][7:0]    port_in_data,
  output logic [NUM_PORTS-1:0][7:0]    port_out_data,
  output logic [NUM_PORTS-1:0]         port_out_stb,
  output logic                         irq
);

  // Reject configurations the decode cannot handle.
  if (OUT_BASE[3:0] != 4'h0 || IN_BASE[3:0] != 4'h0) begin : g_err_align
    $error("io_port_responder: window bases must be 16-aligned");
  end
  if (OUT_BASE[7:4] == IN_BASE[7:4]) begin : g_err_overlap
    $error("io_port_responder: output and input windows overlap");
  end
  if (SYNC_STAGES < 2) begin : g_err_sync
    $error("io_port_responder: SYNC_STAGES must be at least 2");
  end

  logic [NUM_PORTS-1:0][7:0] in_sync;
  port_idx_t                 idx;
  logic                      out_hit;
  logic                      in_hit;

  assign idx     = cpu_addr[3:0];
  assign out_hit = win_hit(cpu_addr, OUT_BASE);
  assign in_hit  = win_hit(cpu_addr, IN_BASE);

  for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_port
    for (genvar gb = 0; gb < 8; gb++) begin : g_bit
      io_sync #(
        .STAGES(SYNC_STAGES)
      ) u_sync (
        .clk  (clk),
        .rst_n(reset),
        .d    (port_in_data[gp][gb]),
        .q    (in_sync[gp][gb])
      );
    end
  end

  // Output registers and their one-cycle write strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      port_out_data <= {NUM_PORTS{OUT_RST_VAL}};
      port_out_stb  <= '0;
    end else begin
      port_out_stb <= '0;
      if (cpu_we && out_hit) begin
        port_out_data[idx] <= cpu_wdata;
        port_out_stb[idx]  <= 1'b1;
      end
    end
  end

  // Registered read path; samples pre-write register contents and holds on a miss.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_rdata  <= '0;
      cpu_rvalid <= 1'b0;
    end else begin
      cpu_rvalid <= cpu_re && (out_hit || in_hit);
      if (cpu_re && out_hit) begin
        cpu_rdata <= port_out_data[idx];
      end else if (cpu_re && in_hit) begin
        cpu_rdata <= in_sync[idx];
      end
    end
  end

`ifdef IO_CHANGE_IRQ_EN
  logic [NUM_PORTS-1:0][7:0] in_prev;
  logic [NUM_PORTS-1:0]      chg;

  // Sticky per-port change flags; a detected change beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_prev <= '0;
      chg     <= '0;
    end else begin
      in_prev <= in_sync;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (in_sync[i] != in_prev[i]) begin
          chg[i] <= 1'b1;
        end else if (cpu_we && in_hit && (idx == port_idx_t'(i))) begin
          chg[i] <= 1'b0;
        end
      end
    end
  end

  assign irq = |chg;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_io_port_responder.sv
// tb/tb_io_port_responder.sv - directed self-checking bench for io_port_responder
module tb_io_port_responder;
  import io_port_pkg::*;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [7:0]                cpu_addr;
  logic [7:0]                cpu_wdata;
  logic                      cpu_we;
  logic                      cpu_re;
  logic [7:0]                cpu_rdata;
  logic                      cpu_rvalid;
  logic [NUM_PORTS-1:0][7:0] port_in_data;
  logic [NUM_PORTS-1:0][7:0] port_out_data;
  logic [NUM_PORTS-1:0]      port_out_stb;
  logic                      irq;

  logic [NUM_PORTS-1:0][7:0] exp_out;
  int n_checks = 0;
  int n_errors = 0;

  io_port_responder dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_we       (cpu_we),
    .cpu_re       (cpu_re),
    .cpu_rdata    (cpu_rdata),
    .cpu_rvalid   (cpu_rvalid),
    .port_in_data (port_in_data),
    .port_out_data(port_out_data),
    .port_out_stb (port_out_stb),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [7:0] data);
    cpu_addr  = addr;
    cpu_wdata = data;
    cpu_we    = 1'b1;
    tick();
    cpu_we    = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] addr);
    cpu_addr = addr;
    cpu_re   = 1'b1;
    tick();
    cpu_re   = 1'b0;
  endtask

  initial begin
    reset        = 1'b0;
    cpu_addr     = 8'h00;
    cpu_wdata    = 8'h00;
    cpu_we       = 1'b0;
    cpu_re       = 1'b0;
    port_in_data = '0;
    exp_out      = '0;

    tick();
    tick();
    check_eq("rst_out", port_out_data, exp_out);
    check_eq("rst_rvalid", cpu_rvalid, 1'b0);
    check_eq("rst_rdata", cpu_rdata, 8'h00);
    check_eq("rst_stb", port_out_stb, 16'h0000);
    check_eq("rst_irq", irq, 1'b0);
    reset = 1'b1;
    tick();

    // Basic write and strobe
    do_write(8'hE3, 8'h5A);
    exp_out[3] = 8'h5A;
    check_eq("wr_e3_data", port_out_data, exp_out);
    check_eq("wr_e3_stb", port_out_stb, 16'h0008);
    tick();
    check_eq("wr_e3_stb_clr", port_out_stb, 16'h0000);

    // Read back output register
    do_read(8'hE3);
    check_eq("rd_e3_rvalid", cpu_rvalid, 1'b1);
    check_eq("rd_e3_rdata", cpu_rdata, 8'h5A);
    tick();
    check_eq("rd_e3_rvalid_clr", cpu_rvalid, 1'b0);

    // Window boundary writes, back to back
    do_write(8'hE0, 8'hA1);
    exp_out[0] = 8'hA1;
    check_eq("wr_e0_stb", port_out_stb, 16'h0001);
    do_write(8'hEF, 8'hFE);
    exp_out[15] = 8'hFE;
    check_eq("wr_ef_stb", port_out_stb, 16'h8000);
    check_eq("wr_bound_data", port_out_data, exp_out);

    // Out-of-window and input-window writes do not touch outputs
    do_write(8'h10, 8'h99);
    check_eq("wr_miss_stb", port_out_stb, 16'h0000);
    do_write(8'hF3, 8'h99);
    check_eq("wr_inwin_stb", port_out_stb, 16'h0000);
    check_eq("wr_miss_data", port_out_data, exp_out);

    // Input port through synchronizer
    port_in_data[7] = 8'hC3;
    tick();
    tick();
    tick();
    do_read(8'hF7);
    check_eq("rd_f7_rdata", cpu_rdata, 8'hC3);
    check_eq("rd_f7_rvalid", cpu_rvalid, 1'b1);

    // Synchronizer latency: change visible to a read only SYNC_STAGES+1 cycles later
    port_in_data[5] = 8'h77;
    cpu_addr = 8'hF5;
    cpu_re   = 1'b1;
    tick();
    check_eq("lat_c1", cpu_rdata, 8'h00);
    tick();
    check_eq("lat_c2", cpu_rdata, 8'h00);
    tick();
    check_eq("lat_c3", cpu_rdata, 8'h77);
    cpu_re = 1'b0;

    // Boundary input port and missed read holding data
    port_in_data[15] = 8'h5C;
    tick();
    tick();
    tick();
    do_read(8'hFF);
    check_eq("rd_ff_rdata", cpu_rdata, 8'h5C);
    do_read(8'h10);
    check_eq("rd_miss_rvalid", cpu_rvalid, 1'b0);
    check_eq("rd_miss_hold", cpu_rdata, 8'h5C);

    // Same-cycle write and read at one index returns the old value
    do_write(8'hE3, 8'h11);
    exp_out[3] = 8'h11;
    cpu_addr  = 8'hE3;
    cpu_wdata = 8'h22;
    cpu_we    = 1'b1;
    cpu_re    = 1'b1;
    tick();
    cpu_we    = 1'b0;
    cpu_re    = 1'b0;
    exp_out[3] = 8'h22;
    check_eq("rw_same_rdata", cpu_rdata, 8'h11);
    check_eq("rw_same_rvalid", cpu_rvalid, 1'b1);
    check_eq("rw_same_data", port_out_data, exp_out);
    do_read(8'hE3);
    check_eq("rw_after_rdata", cpu_rdata, 8'h22);

`ifdef IO_CHANGE_IRQ_EN
    // Clear flags left by earlier input changes
    for (int i = 0; i < NUM_PORTS; i++) begin
      do_write(8'hF0 + 8'(i), 8'h00);
    end
    check_eq("irq_cleared", irq, 1'b0);
    port_in_data[2] = 8'h01;
    tick();
    tick();
    check_eq("irq_early", irq, 1'b0);
    tick();
    check_eq("irq_set", irq, 1'b1);
    do_write(8'hF2, 8'hAA);
    check_eq("irq_clr", irq, 1'b0);
    port_in_data[2] = 8'h00;
    tick();
    tick();
    do_write(8'hF2, 8'h00);
    check_eq("irq_set_wins", irq, 1'b1);
    do_write(8'hF2, 8'h00);
    check_eq("irq_clr2", irq, 1'b0);
`else
    port_in_data[2] = 8'h01;
    tick();
    tick();
    tick();
    tick();
    check_eq("irq_tied0", irq, 1'b0);
`endif

    // Reset asserted mid-access aborts the write and clears outputs at once
    do_write(8'hE4, 8'h44);
    cpu_addr  = 8'hE5;
    cpu_wdata = 8'h33;
    cpu_we    = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    exp_out = '0;
    check_eq("mid_rst_out", port_out_data, exp_out);
    check_eq("mid_rst_stb", port_out_stb, 16'h0000);
    check_eq("mid_rst_rvalid", cpu_rvalid, 1'b0);
    check_eq("mid_rst_rdata", cpu_rdata, 8'h00);
    tick();
    check_eq("mid_rst_no_wr", port_out_data, exp_out);
    check_eq("mid_rst_irq", irq, 1'b0);
    cpu_we = 1'b0;
    reset  = 1'b1;
    tick();
    check_eq("post_rst_out", port_out_data, exp_out);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
